// File: rtl/instr_prefetch_queue.sv
// Prefetch queue feeding fetch: issues sequential word fetches and buffers in-order {PC, instr} pairs.
// Response -> InstrValid in one cycle; requests stop when occupancy + outstanding reaches DEPTH; Stall holds the head.
module instr_prefetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Redirect,
  input  logic [XLEN-1:0] RedirectPC,
  input  logic            Stall,
  output logic            ImemReqValid,
  input  logic            ImemReqReady,
  output logic [XLEN-1:0] ImemReqAddr,
  input  logic            ImemRespValid,
  input  logic [XLEN-1:0] ImemRespData,
  output logic            InstrValid,
  output logic [XLEN-1:0] InstrF,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCPlus4F
);

  localparam int              AW      = $clog2(DEPTH);
  localparam int              CW      = AW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]   ONE_C   = CW'(1);
  localparam logic [AW-1:0]   ONE_P   = AW'(1);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] fetchPc;
  logic [XLEN-1:0] respPc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   dropCnt;
  logic [CW-1:0]   inFlight;
  logic [AW-1:0]   rdPtr;
  logic [AW-1:0]   wrPtr;
  logic [XLEN-1:0] pcMem    [DEPTH];
  logic [XLEN-1:0] instrMem [DEPTH];
  logic            reqFire;
  logic            respFire;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] redirectAligned;
  logic            unusedRedirectLsbs;

  // Capping occupancy + outstanding at DEPTH guarantees every kept response has a slot.
  assign ImemReqValid = !RST && !Redirect && ((count + outstanding) < DEPTH_C);
  assign ImemReqAddr  = fetchPc;

  assign reqFire  = ImemReqValid && ImemReqReady;
  assign respFire = !RST && ImemRespValid && (outstanding != '0);
  assign push     = respFire && (dropCnt == '0) && !Redirect;
  assign pop      = InstrValid && !Stall && !Redirect;

  // Requests still owed by memory after this cycle's response, all of them wrong-path on a redirect.
  assign inFlight        = outstanding - {{AW{1'b0}}, respFire};
  assign redirectAligned = {RedirectPC[XLEN-1:2], 2'b00};
  assign unusedRedirectLsbs = ^RedirectPC[1:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetchPc     <= RESET_PC;
      respPc      <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      dropCnt     <= '0;
      rdPtr       <= '0;
      wrPtr       <= '0;
    end else if (Redirect) begin
      fetchPc     <= redirectAligned;
      respPc      <= redirectAligned;
      count       <= '0;
      rdPtr       <= '0;
      wrPtr       <= '0;
      outstanding <= inFlight;
      dropCnt     <= inFlight;
    end else begin
      if (reqFire) fetchPc <= fetchPc + PC_STEP;
      outstanding <= outstanding + {{AW{1'b0}}, reqFire} - {{AW{1'b0}}, respFire};
      if (respFire && (dropCnt != '0)) dropCnt <= dropCnt - ONE_C;
      if (push) begin
        respPc <= respPc + PC_STEP;
        wrPtr  <= wrPtr + ONE_P;
      end
      if (pop) rdPtr <= rdPtr + ONE_P;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      pcMem[wrPtr]    <= respPc;
      instrMem[wrPtr] <= ImemRespData;
    end
  end

  // Head fields read as zero while empty so stale entries never leak out.
  always_comb begin
    InstrValid = (count != '0);
    InstrF     = '0;
    PCF        = '0;
    PCPlus4F   = '0;
    if (InstrValid) begin
      InstrF   = instrMem[rdPtr];
      PCF      = pcMem[rdPtr];
      PCPlus4F = pcMem[rdPtr] + PC_STEP;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a queue-level model of fetched and in-flight instructions.
module tb_instr_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        CLK, RST, Redirect, Stall, ImemReqReady, ImemRespValid;
  logic        ImemReqValid, InstrValid;
  logic [31:0] RedirectPC, ImemReqAddr, ImemRespData, InstrF, PCF, PCPlus4F;

  instr_prefetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .CLK(CLK), .RST(RST), .Redirect(Redirect), .RedirectPC(RedirectPC), .Stall(Stall),
    .ImemReqValid(ImemReqValid), .ImemReqReady(ImemReqReady), .ImemReqAddr(ImemReqAddr),
    .ImemRespValid(ImemRespValid), .ImemRespData(ImemRespData),
    .InstrValid(InstrValid), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F)
  );

  typedef struct { logic [31:0] pc; logic [31:0] data; } entry_t;
  typedef struct { logic [31:0] addr; bit wrong; } req_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  entry_t      q[$];           // instructions fetch should see, in order
  req_t        inflight[$];    // requests memory still owes, tagged if wrong-path
  mreq_t       memPending[$];  // memory side: accepted requests and their due cycle
  logic [31:0] mFetchPc = RESET_PC;

  int checks = 0, errors = 0, cyc = 0, fixedLat = 1, dutReqs = 0;
  bit modelOn = 0, strayEn = 0, respFromMem = 0;

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  function automatic logic [31:0] memData(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic memPush(input logic [31:0] addr);
    int due;
    due = cyc + ((fixedLat > 0) ? fixedLat : int'($urandom_range(1, 4)));
    if (memPending.size() > 0 && due <= memPending[memPending.size()-1].due)
      due = memPending[memPending.size()-1].due + 1;
    memPending.push_back('{addr, due});
  endtask

  // Called at the falling edge with control inputs already set: drive memory, settle, compare.
  task automatic preCycle();
    bit expV, expReq;
    respFromMem   = 0;
    ImemRespValid = 0;
    ImemRespData  = '0;
    if (!RST && memPending.size() > 0 && memPending[0].due <= cyc) begin
      ImemRespValid = 1;
      ImemRespData  = memData(memPending[0].addr);
      respFromMem   = 1;
    end else if (strayEn && (RST || (memPending.size() == 0 && $urandom_range(0, 5) == 0))) begin
      ImemRespValid = 1;
      ImemRespData  = $urandom;
    end
    #1;
    if (modelOn) begin
      expV   = (q.size() > 0);
      expReq = !RST && !Redirect && (q.size() + inflight.size() < DEPTH);
      chk("InstrValid", 32'(InstrValid), 32'(expV));
      if (expV) begin
        chk("PCF", PCF, q[0].pc);
        chk("InstrF", InstrF, q[0].data);
        chk("PCPlus4F", PCPlus4F, q[0].pc + 32'd4);
      end
      chk("ImemReqValid", 32'(ImemReqValid), 32'(expReq));
      if (expReq) chk("ImemReqAddr", ImemReqAddr, mFetchPc);
    end
    if (ImemReqValid === 1'b1 && ImemReqReady) dutReqs++;
  endtask

  // Apply the clock edge to the model, then advance to the next falling edge.
  task automatic advance();
    bit   expReq, reqFire, popF, respF;
    req_t e;
    if (RST) begin
      q.delete();
      inflight.delete();
      memPending.delete();
      mFetchPc = RESET_PC;
    end else begin
      expReq  = !Redirect && (q.size() + inflight.size() < DEPTH);
      reqFire = expReq && ImemReqReady;
      popF    = (q.size() > 0) && !Stall && !Redirect;
      respF   = ImemRespValid && (inflight.size() > 0);
      if (respFromMem) memPending.delete(0);
      if (respF) e = inflight.pop_front();
      if (Redirect) begin
        q.delete();
        foreach (inflight[i]) inflight[i].wrong = 1;
        mFetchPc = {RedirectPC[31:2], 2'b00};
      end else begin
        if (popF) q.delete(0);
        if (respF && !e.wrong) q.push_back('{e.addr, ImemRespData});
        if (reqFire) begin
          inflight.push_back('{mFetchPc, 1'b0});
          memPush(mFetchPc);
          mFetchPc = mFetchPc + 32'd4;
        end
      end
    end
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
  endtask

  task automatic cycle();
    preCycle();
    advance();
  endtask

  task automatic doReset();
    RST = 1; Redirect = 0; Stall = 0; ImemReqReady = 1;
    cycle();
    cycle();
    RST = 0;
  endtask

  task automatic waitValid(input string name, input logic [31:0] expPc);
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      preCycle();
      if (InstrValid === 1'b1) begin
        found = 1;
        chk({name, "_pc"}, PCF, expPc);
        chk({name, "_instr"}, InstrF, memData(expPc));
        chk({name, "_pc4"}, PCPlus4F, expPc + 32'd4);
      end
      advance();
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout no InstrValid within 20 cycles", name);
    end
  endtask

  initial begin
    RST = 1; Redirect = 0; RedirectPC = '0; Stall = 0; ImemReqReady = 1;
    ImemRespValid = 0; ImemRespData = '0;
    @(negedge CLK);
    cycle();
    modelOn = 1;

    // Reset state
    preCycle();
    chk("rst_valid", 32'(InstrValid), 32'd0);
    chk("rst_reqvalid", 32'(ImemReqValid), 32'd0);
    chk("rst_pcf", PCF, 32'd0);
    chk("rst_instr", InstrF, 32'd0);
    chk("rst_pc4", PCPlus4F, 32'd0);
    advance();
    RST = 0;

    // 1-cycle memory streaming
    fixedLat = 1;
    preCycle(); chk("t1_req0", 32'(ImemReqValid), 32'd1); chk("t1_addr0", ImemReqAddr, 32'h0); advance();
    preCycle(); chk("t1_addr4", ImemReqAddr, 32'h4); chk("t1_notyet", 32'(InstrValid), 32'd0); advance();
    preCycle(); chk("t1_valid", 32'(InstrValid), 32'd1); chk("t1_pc0", PCF, 32'h0);
    chk("t1_instr0", InstrF, memData(32'h0)); advance();
    preCycle(); chk("t1_pc4", PCF, 32'h4); advance();
    preCycle(); chk("t1_pc8", PCF, 32'h8); chk("t1_instr8", InstrF, memData(32'h8)); advance();

    // Stall fills the queue to exactly DEPTH requests
    doReset();
    Stall = 1;
    dutReqs = 0;
    repeat (10) cycle();
    chk("t2_reqs", 32'(dutReqs), 32'd4);
    preCycle(); chk("t2_head", PCF, 32'h0); chk("t2_full", 32'(ImemReqValid), 32'd0); advance();
    Stall = 0;
    preCycle(); chk("t2_pop0", PCF, 32'h0); advance();
    preCycle(); chk("t2_pop4", PCF, 32'h4); chk("t2_resume", ImemReqAddr, 32'h10);
    chk("t2_resumev", 32'(ImemReqValid), 32'd1); advance();
    preCycle(); chk("t2_pop8", PCF, 32'h8); advance();
    preCycle(); chk("t2_pop12", PCF, 32'hC); advance();

    // Redirect with several wrong-path requests in flight
    doReset();
    fixedLat = 3;
    repeat (6) cycle();
    Redirect = 1; RedirectPC = 32'h100;
    preCycle(); chk("t3_noreq", 32'(ImemReqValid), 32'd0); advance();
    Redirect = 0;
    preCycle(); chk("t3_addr", ImemReqAddr, 32'h100); advance();
    waitValid("t3_first", 32'h100);

    // Redirect together with a response and a pop
    doReset();
    fixedLat = 1;
    repeat (5) cycle();
    Redirect = 1; RedirectPC = 32'h3000;
    preCycle(); chk("t4_resp", 32'(ImemRespValid), 32'd1); chk("t4_popable", 32'(InstrValid), 32'd1);
    chk("t4_noreq", 32'(ImemReqValid), 32'd0); advance();
    Redirect = 0;
    preCycle(); chk("t4_empty", 32'(InstrValid), 32'd0); chk("t4_addr", ImemReqAddr, 32'h3000); advance();
    waitValid("t4_first", 32'h3000);

    // Misaligned target and address wrap
    Redirect = 1; RedirectPC = 32'h203; cycle();
    Redirect = 0;
    preCycle(); chk("t5_align", ImemReqAddr, 32'h200); advance();
    Redirect = 1; RedirectPC = 32'hFFFF_FFFC; cycle();
    Redirect = 0;
    preCycle(); chk("t5_top", ImemReqAddr, 32'hFFFF_FFFC); advance();
    preCycle(); chk("t5_wrapv", 32'(ImemReqValid), 32'd1); chk("t5_wrap", ImemReqAddr, 32'h0); advance();
    waitValid("t5_first", 32'hFFFF_FFFC);

    // Reset mid-traffic with stray responses
    doReset();
    fixedLat = 2;
    Stall = 1;
    repeat (4) cycle();
    preCycle(); chk("t6_queued", 32'(InstrValid), 32'd1); chk("t6_full", 32'(ImemReqValid), 32'd0); advance();
    strayEn = 1;
    RST = 1;
    preCycle(); chk("t6_rstreq", 32'(ImemReqValid), 32'd0); advance();
    preCycle(); chk("t6_cleared", 32'(InstrValid), 32'd0); advance();
    RST = 0; Stall = 0;
    preCycle(); chk("t6_empty", 32'(InstrValid), 32'd0); chk("t6_addr", ImemReqAddr, RESET_PC); advance();

    // Randomized traffic
    fixedLat = 0;
    for (int n = 0; n < 3000; n++) begin
      RST          = ($urandom_range(0, 299) == 0);
      Redirect     = ($urandom_range(0, 19) == 0);
      RedirectPC   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      Stall        = $urandom_range(0, 1);
      ImemReqReady = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
